// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline definitions: data width, PC constants and the IF/ID payload layout.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INCREMENT     = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
        logic            valid;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_if_id_register.sv
// Generic pipeline register with reset, squash (bubble insert, PC fields kept), load and hold.
module if_id_register
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = INSTR_NOP
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_load,
    input  logic            i_squash,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_pcPlus4,
    input  logic [XLEN-1:0] i_instr,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pcPlus4,
    output logic [XLEN-1:0] o_instr,
    output logic            o_valid
);

    if_id_t r_stage;

    // Squash only replaces the instruction; the PC fields keep their last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage <= '{pc: '0, pc_plus4: '0, instr: NOP_INSTR, valid: 1'b0};
        end else if (i_squash) begin
            r_stage.instr <= NOP_INSTR;
            r_stage.valid <= 1'b0;
        end else if (i_load) begin
            r_stage <= '{pc: i_pc, pc_plus4: i_pcPlus4, instr: i_instr, valid: 1'b1};
        end
    end

    assign o_pc      = r_stage.pc;
    assign o_pcPlus4 = r_stage.pc_plus4;
    assign o_instr   = r_stage.instr;
    assign o_valid   = r_stage.valid;

endmodule

// File: rtl/fetch_stage.sv
// RV32IM instruction fetch: PC register, IF/ID capture, stall hold and EX redirect squash.
// Optional macro FETCH_MISALIGN_CHECK_EN enables the registered misaligned-redirect flag.
module fetch_stage
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = INSTR_NOP
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] pc_address,
    input  logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc_plus4,
    output logic [XLEN-1:0] if_id_instr,
    output logic            if_id_valid,
    output logic            misaligned_fault
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pcPlus4;
    logic [XLEN-1:0] w_redirectPc;
    logic            w_load;

    assign w_pcPlus4    = r_pc + PC_INCREMENT;
    assign w_redirectPc = redirect_target & ~32'h0000_0003;
    assign w_load       = !stall && !redirect_valid;
    assign pc_address   = r_pc;

    // Priority: reset, then redirect (overrides stall), then stall hold, then sequential advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= w_redirectPc;
        end else if (!stall) begin
            r_pc <= w_pcPlus4;
        end
    end

    if_id_register #(
        .NOP_INSTR(NOP_INSTR)
    ) u_ifId (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_squash (redirect_valid),
        .i_pc     (r_pc),
        .i_pcPlus4(w_pcPlus4),
        .i_instr  (instruction),
        .o_pc     (if_id_pc),
        .o_pcPlus4(if_id_pc_plus4),
        .o_instr  (if_id_instr),
        .o_valid  (if_id_valid)
    );

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_misalignedFault;

    // Recomputed every edge, so it lasts one cycle and a stall cannot stretch it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_misalignedFault <= 1'b0;
        end else begin
            r_misalignedFault <= redirect_valid && (redirect_target[1:0] != 2'b00);
        end
    end

    assign misaligned_fault = r_misalignedFault;
`else
    assign misaligned_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a combinational instruction memory model.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] pc_address;
    logic [31:0] instruction;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        misaligned_fault;

    int checkCount = 0;
    int errorCount = 0;

`ifdef FETCH_MISALIGN_CHECK_EN
    localparam logic misalignEn = 1'b1;
`else
    localparam logic misalignEn = 1'b0;
`endif

    fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc_address      (pc_address),
        .instruction     (instruction),
        .if_id_pc        (if_id_pc),
        .if_id_pc_plus4  (if_id_pc_plus4),
        .if_id_instr     (if_id_instr),
        .if_id_valid     (if_id_valid),
        .misaligned_fault(misaligned_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small program at 0..8; every other address returns a tag derived from the address.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        case (addr)
            32'h0:   return 32'h0000_0013;
            32'h4:   return 32'h0000_0093;
            32'h8:   return 32'h0010_0113;
            default: return 32'h1000_0000 ^ addr;
        endcase
    endfunction

    always_comb instruction = memWord(pc_address);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic stl, input logic rdv, input logic [31:0] tgt);
        reset           = rst;
        stall           = stl;
        redirect_valid  = rdv;
        redirect_target = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic checkIfId(input string tag, input logic [31:0] pc, input logic [31:0] pcPlus4,
                             input logic [31:0] instr, input logic valid);
        checkOutput({tag, ".if_id_pc"}, if_id_pc, pc);
        checkOutput({tag, ".if_id_pc_plus4"}, if_id_pc_plus4, pcPlus4);
        checkOutput({tag, ".if_id_instr"}, if_id_instr, instr);
        checkOutput({tag, ".if_id_valid"}, {31'b0, if_id_valid}, {31'b0, valid});
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        #1;
        $display("[TB] starting fetch_stage directed test");

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("reset.pc", pc_address, 32'h0);
        checkIfId("reset", 32'h0, 32'h0, 32'h13, 1'b0);
        checkOutput("reset.fault", {31'b0, misaligned_fault}, 32'h0);

        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("run1.pc", pc_address, 32'h4);
        checkIfId("run1", 32'h0, 32'h4, 32'h13, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("run2.pc", pc_address, 32'h8);
        checkIfId("run2", 32'h4, 32'h8, 32'h93, 1'b1);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
            checkOutput("stall.pc", pc_address, 32'h8);
            checkIfId("stall", 32'h4, 32'h8, 32'h93, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("unstall.pc", pc_address, 32'hC);
        checkIfId("unstall", 32'h8, 32'hC, 32'h0010_0113, 1'b1);

        applyStimulus(1'b0, 1'b0, 1'b1, 32'h40);
        checkOutput("redir.pc", pc_address, 32'h40);
        checkIfId("redir", 32'h8, 32'hC, 32'h13, 1'b0);
        checkOutput("redir.fault", {31'b0, misaligned_fault}, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("postredir.pc", pc_address, 32'h44);
        checkIfId("postredir", 32'h40, 32'h44, 32'h1000_0040, 1'b1);

        applyStimulus(1'b0, 1'b1, 1'b1, 32'h20);
        checkOutput("redirstall.pc", pc_address, 32'h20);
        checkIfId("redirstall", 32'h40, 32'h44, 32'h13, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkIfId("afterredirstall", 32'h20, 32'h24, 32'h1000_0020, 1'b1);

        applyStimulus(1'b0, 1'b0, 1'b1, 32'h100);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h200);
        checkOutput("b2b.pc", pc_address, 32'h200);
        checkOutput("b2b.valid", {31'b0, if_id_valid}, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkIfId("afterb2b", 32'h200, 32'h204, 32'h1000_0200, 1'b1);

        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        checkOutput("wrapsetup.pc", pc_address, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("wrap.pc", pc_address, 32'h0);
        checkIfId("wrap", 32'hFFFF_FFFC, 32'h0, 32'hEFFF_FFFC, 1'b1);

        applyStimulus(1'b0, 1'b0, 1'b1, 32'h2C);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("prereset.pc", pc_address, 32'h30);
        checkIfId("prereset", 32'h2C, 32'h30, 32'h1000_002C, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("midreset.pc", pc_address, 32'h0);
        checkIfId("midreset", 32'h0, 32'h0, 32'h13, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h23);
        checkOutput("resetredir.pc", pc_address, 32'h0);
        checkOutput("resetredir.fault", {31'b0, misaligned_fault}, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("postreset.pc", pc_address, 32'h4);
        checkIfId("postreset", 32'h0, 32'h4, 32'h13, 1'b1);

        applyStimulus(1'b0, 1'b0, 1'b1, 32'h22);
        checkOutput("misalign.pc", pc_address, 32'h20);
        checkOutput("misalign.fault", {31'b0, misaligned_fault}, {31'b0, misalignEn});
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("misalignclr.fault", {31'b0, misaligned_fault}, 32'h0);
        checkOutput("misalignclr.pc", pc_address, 32'h20);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h57);
        checkOutput("misalign2.pc", pc_address, 32'h54);
        checkOutput("misalign2.fault", {31'b0, misaligned_fault}, {31'b0, misalignEn});
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("misalign2clr.fault", {31'b0, misaligned_fault}, 32'h0);
        checkOutput("misalign2clr.valid", {31'b0, if_id_valid}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
